fp_addsub_seq: RTL
==================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 6, exponent field width (>= 3).
REQ-002 SHALL have parameter MAN_W, default 25, stored-mantissa width, hidden 1 implicit (>= 4).
REQ-003 SHALL derive WIDTH = 1+EXP_W+MAN_W and BIAS = 2^(EXP_W-1)-1; word layout [WIDTH-1] sign, then exponent, then mantissa in LSBs.
REQ-004 clock_100kHz  in  1  clock, rising edge.
REQ-005 reset  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  operands present.
REQ-007 in_ready  out  1  block can accept; high only in IDLE.
REQ-008 op_sub  in  1  0: A+B, 1: A-B.
REQ-009 op_a, op_b  in  WIDTH  operands.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 data_out  out  WIDTH  result.
REQ-013 status_out  out  4  [0] exact, [1] overflow, [2] underflow, [3] inexact.

Function
REQ-014 SHALL run FSM IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
REQ-015 SHALL capture op_a, op_b, op_sub on the edge where in_valid && in_ready; inputs ignored in every other state.
REQ-016 UNPACK: invert B sign if op_sub; exponent 0 operand = zero (no hidden bit); swap so A has larger magnitude (exponent, then mantissa); diff = expA-expB.
REQ-017 ALIGN: shift B mantissa right by diff in one cycle, OR all shifted-out bits into sticky; diff > MAN_W+2 leaves only sticky.
REQ-018 ADD: signs equal -> add, else subtract, on MAN_W+4-bit extended mantissas (carry, hidden, mantissa, guard, round; sticky kept separately).
REQ-019 NORM: carry -> shift right 1, exp+1, one cycle; else shift left 1 per cycle, exp-1, until hidden bit set; zero result skips to ROUND as +0.
REQ-020 ROUND: per REQ-031/032 using guard/round/sticky; mantissa carry-out renormalises within ROUND (exp+1).
REQ-021 Result sign = sign of larger-magnitude operand; exact-zero result = +0.
REQ-022 Overflow: final exponent >= 2^EXP_W-1 -> data_out = {sign, all-ones exp, 0 mantissa}, status [1] and [3].
REQ-023 Underflow: final exponent <= 0 on nonzero result -> data_out = {sign, 0...}, status [2] and [3].
REQ-024 status[3] SHALL be set whenever any discarded bit is nonzero; status[0] set only if no other status bit set.
REQ-025 Latency acceptance-edge to out_valid SHALL be 5+L cycles, L = left-shift steps in NORM.
REQ-026 DONE: out_valid high, data_out/status_out stable until out_valid && out_ready edge; then IDLE, out_valid low same edge.
REQ-027 data_out/status_out SHALL hold last result while IDLE.

Reset
REQ-028 reset low at any time, including mid-operation, SHALL abort, enter IDLE, clear all internal registers.
REQ-029 During reset: out_valid 0, data_out 0, status_out 0, in_ready 1.
REQ-030 First acceptance possible on first rising edge after reset deasserts.

Configuration
REQ-031 Macro FP_ROUND_NEAREST_EN defined: round-to-nearest, ties-to-even.
REQ-032 FP_ROUND_NEAREST_EN undefined: truncate (toward zero); inexact flagging unchanged.

Verification (defaults, BIAS 31)
REQ-033 0x3E000000 + 0x3E000000, op_sub 0 -> 0x40000000, status 4'b0001, out_valid 5 cycles after acceptance.
REQ-034 0x3E000001 + 0x0A000000 -> 0x3E000002 with FP_ROUND_NEAREST_EN, 0x3E000001 without; status 4'b1000 both.
REQ-035 0x7C000000 + 0x7C000000 -> 0x7E000000, status 4'b1010; 0x03000000 - 0x02000000 (op_sub 1) -> 0x00000000, status 4'b1100.
REQ-036 0x3E000000 - 0x3E000000 -> 0x00000000, status 4'b0001; out_ready low 10 cycles -> out_valid, data_out stable, in_ready 0.
REQ-037 reset pulsed low while in NORM -> out_valid 0, data_out 0, status 0, in_ready 1; next accepted operation correct.

Source files
------------

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: sequential floating-point adder/subtractor.
//
// Word layout (WIDTH = 1 + EXP_W + MAN_W): [WIDTH-1] sign, then the biased
// exponent (bias 2^(EXP_W-1)-1), then the stored mantissa in the LSBs with
// an implicit hidden 1. An exponent field of zero encodes a zero operand.
//
// One operation walks IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// NORM spends one extra cycle per left-shift step, so the result appears
// 5 + L cycles after the accepting edge.
//
// Build option: define FP_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise results are truncated toward zero. Inexact flagging is the same
// in both builds.
//
// Ports:
//   clock_100kHz  rising-edge clock
//   reset         asynchronous active-low reset, aborts any operation
//   in_valid      operands present       in_ready   high only in IDLE
//   op_sub        0: A+B, 1: A-B         op_a/op_b  operands
//   out_valid     result available       out_ready  consumer takes result
//   data_out      result word, held until the next result
//   status_out    [0] exact [1] overflow [2] underflow [3] inexact
module fp_addsub_seq #(
    parameter  int EXP_W = 6,
    parameter  int MAN_W = 25,
    localparam int WIDTH = 1 + EXP_W + MAN_W
) (
    input  logic             clock_100kHz,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic [3:0]       status_out
);
    // Extended mantissa: [carry][hidden][MAN_W mantissa][guard][round].
    localparam int EXT = MAN_W + 4;
    // Working exponent is signed and wide enough to go below zero by a full
    // normalisation sweep and above the all-ones code after a carry.
    localparam int EW  = EXP_W + $clog2(MAN_W + 4) + 2;
    localparam logic signed [EW-1:0] EXP_ONE   = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO  = EW'(0);
    localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
    localparam logic [31:0]          ALIGN_LIM = 32'(MAN_W + 2);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_ALIGN  = 3'd2,
        ST_ADD    = 3'd3,
        ST_NORM   = 3'd4,
        ST_ROUND  = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic                 sub_q, sub_d;
    logic                 sign_q, sign_d;
    logic                 eff_sub_q, eff_sub_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic [MAN_W:0]       ma_q, ma_d, mb_q, mb_d;
    logic [EXP_W-1:0]     diff_q, diff_d;
    logic [EXT-1:0]       bsh_q, bsh_d;
    logic                 sticky_q, sticky_d;
    logic [EXT-1:0]       sum_q, sum_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [3:0]           status_q, status_d;
    logic                 out_valid_q, out_valid_d;
    logic                 in_ready_q, in_ready_d;

    // ---------------- UNPACK datapath ----------------
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W:0]   ma_s, mb_s;
    logic             sa_s, sb_s, swap_s;

    assign ea_s = a_q[WIDTH-2 -: EXP_W];
    assign eb_s = b_q[WIDTH-2 -: EXP_W];
    // Exponent zero means the operand is zero: no hidden bit, fraction ignored.
    assign ma_s = (ea_s == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}} : {1'b1, a_q[MAN_W-1:0]};
    assign mb_s = (eb_s == {EXP_W{1'b0}}) ? {(MAN_W+1){1'b0}} : {1'b1, b_q[MAN_W-1:0]};
    assign sa_s = a_q[WIDTH-1];
    assign sb_s = b_q[WIDTH-1] ^ sub_q;
    // Magnitude compare: exponent first, then mantissa.
    assign swap_s = {eb_s, mb_s} > {ea_s, ma_s};

    // ---------------- ALIGN datapath ----------------
    logic [EXT-1:0]   bext_s;
    logic [2*EXT-1:0] bwide_s;
    logic             far_s;

    assign bext_s  = {1'b0, mb_q, 2'b00};
    // Low half collects everything shifted past the round bit (sticky source).
    assign bwide_s = {bext_s, {EXT{1'b0}}} >> diff_q;
    assign far_s   = {{(32-EXP_W){1'b0}}, diff_q} > ALIGN_LIM;

    // ---------------- ADD datapath ----------------
    logic [EXT-1:0] aext_s, add_s;
    logic [EXT:0]   sub_s;

    assign aext_s = {1'b0, ma_q, 2'b00};
    assign add_s  = aext_s + bsh_q;
    // Sticky takes part in the subtraction as a bit below round so that the
    // borrow from discarded bits reaches the kept bits.
    assign sub_s  = {aext_s, 1'b0} - {bsh_q, sticky_q};

    // ---------------- ROUND datapath ----------------
    logic                 inexact_s, rup_s;
    logic [MAN_W+1:0]     rman_s;
    logic signed [EW-1:0] rexp_s;
    logic [MAN_W-1:0]     rfrac_s;

    assign inexact_s = sum_q[1] | sum_q[0] | sticky_q;
`ifdef FP_ROUND_NEAREST_EN
    // Round up above half, or on an exact half when the kept LSB is odd.
    assign rup_s = sum_q[1] & (sum_q[0] | sticky_q | sum_q[2]);
`else
    assign rup_s = 1'b0;
`endif
    assign rman_s  = {1'b0, sum_q[EXT-2:2]} + {{(MAN_W+1){1'b0}}, rup_s};
    // A rounding carry leaves 10.00..0; renormalise by one position.
    assign rexp_s  = rman_s[MAN_W+1] ? (exp_q + EXP_ONE) : exp_q;
    assign rfrac_s = rman_s[MAN_W+1] ? rman_s[MAN_W:1] : rman_s[MAN_W-1:0];

    // Next-state and datapath register updates for the operation sequence.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        sign_d      = sign_q;
        eff_sub_d   = eff_sub_q;
        exp_d       = exp_q;
        ma_d        = ma_q;
        mb_d        = mb_q;
        diff_d      = diff_q;
        bsh_d       = bsh_q;
        sticky_d    = sticky_q;
        sum_d       = sum_q;
        data_d      = data_q;
        status_d    = status_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    state_d = ST_UNPACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_UNPACK: begin
                if (swap_s) begin
                    sign_d = sb_s;
                    exp_d  = $signed({{(EW-EXP_W){1'b0}}, eb_s});
                    ma_d   = mb_s;
                    mb_d   = ma_s;
                    diff_d = eb_s - ea_s;
                end else begin
                    sign_d = sa_s;
                    exp_d  = $signed({{(EW-EXP_W){1'b0}}, ea_s});
                    ma_d   = ma_s;
                    mb_d   = mb_s;
                    diff_d = ea_s - eb_s;
                end
                eff_sub_d = sa_s ^ sb_s;
                state_d   = ST_ALIGN;
            end
            ST_ALIGN: begin
                if (far_s) begin
                    bsh_d    = {EXT{1'b0}};
                    sticky_d = |mb_q;
                end else begin
                    bsh_d    = bwide_s[2*EXT-1:EXT];
                    sticky_d = |bwide_s[EXT-1:0];
                end
                state_d = ST_ADD;
            end
            ST_ADD: begin
                if (eff_sub_q) begin
                    sum_d    = sub_s[EXT:1];
                    sticky_d = sub_s[0];
                end else begin
                    sum_d    = add_s;
                end
                state_d = ST_NORM;
            end
            ST_NORM: begin
                if (sum_q == {EXT{1'b0}}) begin
                    state_d = ST_ROUND;
                end else if (sum_q[EXT-1]) begin
                    sum_d    = {1'b0, sum_q[EXT-1:1]};
                    sticky_d = sticky_q | sum_q[0];
                    exp_d    = exp_q + EXP_ONE;
                    state_d  = ST_ROUND;
                end else if (sum_q[EXT-2]) begin
                    state_d = ST_ROUND;
                end else begin
                    // Zero shifts into round: the kept sticky still covers
                    // whatever lay below it.
                    sum_d   = {sum_q[EXT-2:0], 1'b0};
                    exp_d   = exp_q - EXP_ONE;
                    state_d = ST_NORM;
                end
            end
            ST_ROUND: begin
                if (sum_q == {EXT{1'b0}}) begin
                    data_d   = {WIDTH{1'b0}};
                    status_d = 4'b0001;
                end else if (rexp_s >= EXP_MAX) begin
                    data_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    status_d = 4'b1010;
                end else if (rexp_s <= EXP_ZERO) begin
                    data_d   = {sign_q, {(WIDTH-1){1'b0}}};
                    status_d = 4'b1100;
                end else begin
                    data_d   = {sign_q, rexp_s[EXP_W-1:0], rfrac_s};
                    status_d = {inexact_s, 2'b00, ~inexact_s};
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset clears everything and idles.
    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            sub_q       <= 1'b0;
            sign_q      <= 1'b0;
            eff_sub_q   <= 1'b0;
            exp_q       <= EXP_ZERO;
            ma_q        <= {(MAN_W+1){1'b0}};
            mb_q        <= {(MAN_W+1){1'b0}};
            diff_q      <= {EXP_W{1'b0}};
            bsh_q       <= {EXT{1'b0}};
            sticky_q    <= 1'b0;
            sum_q       <= {EXT{1'b0}};
            data_q      <= {WIDTH{1'b0}};
            status_q    <= 4'b0000;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            sign_q      <= sign_d;
            eff_sub_q   <= eff_sub_d;
            exp_q       <= exp_d;
            ma_q        <= ma_d;
            mb_q        <= mb_d;
            diff_q      <= diff_d;
            bsh_q       <= bsh_d;
            sticky_q    <= sticky_d;
            sum_q       <= sum_d;
            data_q      <= data_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign data_out   = data_q;
    assign status_out = status_q;

endmodule
